// File: rtl/f_ifu_pkg.sv
// +--------------------------------------------------------------------+
// | f_ifu_pkg : shared state encodings and constants for the fetch unit|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package f_ifu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_f_req  = 2'd0;
  localparam state_t c_f_wait = 2'd1;
  localparam state_t c_f_hold = 2'd2;

  localparam logic [31:0] c_reset_pc = 32'h0000_3000;
  localparam logic [31:0] c_nop      = 32'h0000_0000;

  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/f_ifu_ibuf.sv
// +--------------------------------------------------------------------+
// | f_ibuf : one-entry instruction holding register (load/clear)       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module f_ibuf
  import f_ifu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din,
  output logic        valid,
  output logic [31:0] dout
);

  logic        r_valid;
  logic [31:0] r_data;

  // clear wins so a fire edge always leaves the buffer empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= c_nop;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_data  <= c_nop;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= din;
    end
  end

  assign valid = r_valid;
  assign dout  = r_data;

endmodule

`default_nettype wire

// File: rtl/f_ifu.sv
// +--------------------------------------------------------------------+
// | f_ifu : fetch-stage PC owner, single-outstanding instruction fetch |
// | Optional fetch address-error check: F_ADEL_CHECK_EN               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module f_ifu
  import f_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] nPc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_exc_adel
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic        w_adel;
  logic        w_fire;
  logic        w_buf_load;
  logic        w_buf_valid;
  logic [31:0] w_buf_data;

`ifdef F_ADEL_CHECK_EN
  assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < PC_LO) || (r_pc > PC_HI);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{PC_LO, PC_HI};
  assign w_adel       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_f_req;
    else        r_state <= w_state_nxt;
  end

  // a faulting PC never reaches memory; it is presented straight from REQ
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_f_req: begin
        if (!w_adel && im_gnt) w_state_nxt = c_f_wait;
      end
      c_f_wait: begin
        if (im_rvalid) w_state_nxt = stall ? c_f_hold : c_f_req;
      end
      c_f_hold: begin
        if (!stall) w_state_nxt = c_f_req;
      end
      default: w_state_nxt = c_f_req;
    endcase
  end

  always_comb begin
    im_req     = 1'b0;
    f_valid    = 1'b0;
    f_instr    = c_nop;
    f_exc_adel = 1'b0;
    if (reset) begin
      case (r_state)
        c_f_req: begin
          im_req     = !w_adel;
          f_valid    = w_adel;
          f_exc_adel = w_adel;
        end
        c_f_wait: begin
          f_valid = im_rvalid;
          if (im_rvalid) f_instr = im_rdata;
        end
        c_f_hold: begin
          f_valid = w_buf_valid;
          f_instr = w_buf_data;
        end
        default: ;
      endcase
    end
  end

  assign w_fire     = f_valid && !stall;
  assign w_buf_load = (r_state == c_f_wait) && im_rvalid && stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_pc <= RESET_PC;
    else if (w_fire) r_pc <= nPc;
  end

  f_ibuf u_ibuf (
    .clk   (clk),
    .reset (reset),
    .load  (w_buf_load),
    .clear (w_fire),
    .din   (im_rdata),
    .valid (w_buf_valid),
    .dout  (w_buf_data)
  );

  assign im_addr = word_addr(r_pc);
  assign f_pc    = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_f_ifu.sv
// +--------------------------------------------------------------------+
// | tb_f_ifu : directed, table-driven self-checking bench for f_ifu    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_f_ifu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] nPc = 32'h0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_exc_adel;

  int n_checks = 0;
  int n_fail   = 0;

  f_ifu dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .nPc        (nPc),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_gnt     (im_gnt),
    .im_rvalid  (im_rvalid),
    .im_rdata   (im_rdata),
    .f_valid    (f_valid),
    .f_pc       (f_pc),
    .f_instr    (f_instr),
    .f_exc_adel (f_exc_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [31:0] npc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, input logic [31:0] np, input logic g,
                              input logic rv, input logic [31:0] rd, input logic er,
                              input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.stall = st; v.npc = np; v.gnt = g; v.rvalid = rv; v.rdata = rd;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [31:0] np, input logic g,
                       input logic rv, input logic [31:0] rd);
    stall = st; nPc = np; im_gnt = g; im_rvalid = rv; im_rdata = rd;
  endtask

  // sample at negedge, then advance to just after the next rising edge
  task automatic expect_out(input string tag, input int idx, input logic er,
                            input logic [31:0] ea, input logic ev,
                            input logic [31:0] ei, input logic [31:0] ep,
                            input logic eadel);
    @(negedge clk);
    chk({tag, ".im_req"},     idx, {31'b0, im_req},     {31'b0, er});
    if (er) chk({tag, ".im_addr"}, idx, im_addr, ea);
    chk({tag, ".f_valid"},    idx, {31'b0, f_valid},    {31'b0, ev});
    chk({tag, ".f_instr"},    idx, f_instr, ei);
    chk({tag, ".f_pc"},       idx, f_pc, ep);
    chk({tag, ".f_exc_adel"}, idx, {31'b0, f_exc_adel}, {31'b0, eadel});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // zero-wait fetches 3000/3004/3008; nPc noise outside fire; branch to 3040;
    // 3-cycle gnt delay; 1-cycle rvalid delay; stall held 4 cycles into HOLD
    vecs[0]  = mk(0, 32'h0,         1, 0, 32'h0,         1, 32'h3000, 0, 32'h0,         32'h3000);
    vecs[1]  = mk(0, 32'h3004,      0, 1, 32'h1111_0000, 0, 32'h3000, 1, 32'h1111_0000, 32'h3000);
    vecs[2]  = mk(0, 32'h0,         1, 0, 32'h0,         1, 32'h3004, 0, 32'h0,         32'h3004);
    vecs[3]  = mk(0, 32'h3008,      0, 1, 32'h2222_0000, 0, 32'h3004, 1, 32'h2222_0000, 32'h3004);
    vecs[4]  = mk(0, 32'hDEAD_BEEF, 1, 0, 32'h0,         1, 32'h3008, 0, 32'h0,         32'h3008);
    vecs[5]  = mk(0, 32'h3040,      0, 1, 32'h3333_0000, 0, 32'h3008, 1, 32'h3333_0000, 32'h3008);
    vecs[6]  = mk(0, 32'h1234_5678, 0, 1, 32'hBAD0_0000, 1, 32'h3040, 0, 32'h0,         32'h3040);
    vecs[7]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h3040, 0, 32'h0,         32'h3040);
    vecs[8]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h3040, 0, 32'h0,         32'h3040);
    vecs[9]  = mk(0, 32'h0,         1, 0, 32'h0,         1, 32'h3040, 0, 32'h0,         32'h3040);
    vecs[10] = mk(0, 32'h5555_0000, 0, 0, 32'h0,         0, 32'h3040, 0, 32'h0,         32'h3040);
    vecs[11] = mk(1, 32'h6666_0000, 0, 1, 32'h2408_0001, 0, 32'h3040, 1, 32'h2408_0001, 32'h3040);
    vecs[12] = mk(1, 32'h7777_0000, 1, 0, 32'hFFFF_FFFF, 0, 32'h3040, 1, 32'h2408_0001, 32'h3040);
    vecs[13] = mk(1, 32'h0,         0, 1, 32'hEEEE_EEEE, 0, 32'h3040, 1, 32'h2408_0001, 32'h3040);
    vecs[14] = mk(1, 32'h0,         0, 0, 32'h0,         0, 32'h3040, 1, 32'h2408_0001, 32'h3040);
    vecs[15] = mk(0, 32'h3044,      0, 0, 32'h0,         0, 32'h3040, 1, 32'h2408_0001, 32'h3040);
    vecs[16] = mk(0, 32'h0,         1, 0, 32'h0,         1, 32'h3044, 0, 32'h0,         32'h3044);

    // reset state
    drive(0, 32'h0, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 32'h0, 0, 32'h0, 32'h3000, 0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].npc, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      expect_out("vec", i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                 vecs[i].e_instr, vecs[i].e_pc, 1'b0);
    end

    // reset asserted while in WAIT; stale rvalid after release is dropped
    drive(0, 32'h0, 0, 0, 32'h0);
    reset = 1'b0;
    expect_out("rst_mid", 0, 0, 32'h0, 0, 32'h0, 32'h3000, 0);
    reset = 1'b1;
    drive(0, 32'h9999_0000, 0, 1, 32'hDEAD_0001);
    expect_out("rst_mid", 1, 1, 32'h3000, 0, 32'h0, 32'h3000, 0);
    drive(0, 32'h0, 1, 0, 32'h0);
    expect_out("rst_mid", 2, 1, 32'h3000, 0, 32'h0, 32'h3000, 0);
    drive(0, 32'h3002, 0, 1, 32'h4444_0000);
    expect_out("rst_mid", 3, 0, 32'h3000, 1, 32'h4444_0000, 32'h3000, 0);

`ifdef F_ADEL_CHECK_EN
    // misaligned PC: presented as exception, no request, held under stall
    drive(1, 32'h0, 1, 0, 32'h0);
    expect_out("adel", 0, 0, 32'h0, 1, 32'h0, 32'h3002, 1);
    drive(0, 32'h7000, 1, 0, 32'h0);
    expect_out("adel", 1, 0, 32'h0, 1, 32'h0, 32'h3002, 1);
    drive(0, 32'h3000, 1, 0, 32'h0);
    expect_out("adel", 2, 0, 32'h0, 1, 32'h0, 32'h7000, 1);
    drive(0, 32'h0, 1, 0, 32'h0);
    expect_out("adel", 3, 1, 32'h3000, 0, 32'h0, 32'h3000, 0);
`else
    // no check: a misaligned PC is fetched with bits [1:0] dropped
    drive(0, 32'h0, 1, 0, 32'h0);
    expect_out("noadel", 0, 1, 32'h3000, 0, 32'h0, 32'h3002, 0);
    drive(0, 32'h7000, 0, 1, 32'h5555_0000);
    expect_out("noadel", 1, 0, 32'h3000, 1, 32'h5555_0000, 32'h3002, 0);
    drive(0, 32'h0, 1, 0, 32'h0);
    expect_out("noadel", 2, 1, 32'h7000, 0, 32'h0, 32'h7000, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
